data_mem_responder: RTL

Memory-side responder for the CPU data-memory interface. It replaces the zero-latency combinational data memory with a multi-cycle word RAM that uses a valid/ready request handshake and a one-cycle response pulse. The CPU datapath issues the load/store requests (ALU_result as the address, Read_data_2 as the store data) and stalls until Resp_valid. It enables realistic memory-latency experiments in the MIPS memory hierarchy work.

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_responder_mem_word_ram.sv | 39 +++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, data-path
// widths, legal latency range and the address legality rule.
package data_mem_responder_pkg;

  localparam int WORD_W  = 32;
  localparam int LANES   = 4;
  localparam int CNT_W   = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A word access is legal only when word aligned and inside the RAM.
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                    input int depth_log2);
    return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that only updates on a read.
module mem_word_ram
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write into the storage array.
  // NOTE: the array has no reset branch; clearing it would need a
  // per-word reset path and turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: loaded only by a read, otherwise holds the last word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one request per valid/ready handshake,
// waits LATENCY cycles, performs the RAM access and pulses Resp_valid.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Req_valid,
  input  logic              Req_write,
  input  logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] Write_data,
  input  logic [LANES-1:0]  Byte_en,
  output logic              Req_ready,
  output logic              Resp_valid,
  output logic [WORD_W-1:0] Read_data,
  output logic              Addr_error
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 28) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_LOG2 must be in 1..28");
  end

  // With a single-cycle latency the access happens on the accepting edge,
  // straight from the request inputs; otherwise from the latched request.
  localparam bit              DIRECT   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_write_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [LANES-1:0]   be_q;

  logic               accept;
  logic               fire;
  logic               acc_write;
  logic               acc_bad;
  logic [WORD_W-1:0]  acc_addr;
  logic [WORD_W-1:0]  acc_wdata;
  logic [LANES-1:0]   acc_be;

  assign Req_ready = !RESET && (state != ST_WAIT);
  assign accept    = Req_valid && Req_ready;

  assign acc_write = DIRECT ? Req_write  : req_write_q;
  assign acc_addr  = DIRECT ? Address    : addr_q;
  assign acc_wdata = DIRECT ? Write_data : wdata_q;
  assign acc_be    = DIRECT ? Byte_en    : be_q;
  assign acc_bad   = addr_bad(acc_addr, DEPTH_LOG2);

  // The access edge; RESET suppresses it so an aborted store never commits.
  assign fire = DIRECT ? accept
                       : (!RESET && (state == ST_WAIT) && (cnt == '0));

  mem_word_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (fire && acc_write && !acc_bad),
    .re    (fire && !acc_write && !acc_bad),
    .be    (acc_be),
    .addr  (acc_addr[DEPTH_LOG2+1:2]),
    .wdata (acc_wdata),
    .rdata (Read_data)
  );

  // Request FSM with latency counter and registered response flags.
  // NOTE: every register here uses <= so all updates see pre-edge values
  // regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      Resp_valid  <= 1'b0;
      Addr_error  <= 1'b0;
      req_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      Resp_valid <= 1'b0;
      Addr_error <= 1'b0;
      unique case (state)
        ST_IDLE, ST_RESP: begin
          state <= ST_IDLE;
          if (accept) begin
            req_write_q <= Req_write;
            addr_q      <= Address;
            wdata_q     <= Write_data;
            be_q        <= Byte_en;
            if (DIRECT) begin
              state      <= ST_RESP;
              Resp_valid <= 1'b1;
              Addr_error <= acc_bad;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            Resp_valid <= 1'b1;
            Addr_error <= acc_bad;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
